// File: rtl/cordic_share_arbiter.sv
// cordic_share_arbiter: round-robin session arbiter sharing one vectoring and one rotation CORDIC
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req / grant                    per-requester session request / one-hot registered grant
//   r_vec_* / r_rot_*              per-requester CORDIC issue pulses and packed operands
//   cv_* / cr_* (out)              registered operand bus to the vectoring / rotation CORDIC
//   cv_opvld..cv_mr_start, cr_*    results returning from the CORDICs
//   o_vec_* / o_rot_*              owner-masked result strobes, broadcast result data
//   busy, protocol_err             session active, sticky protocol violation
module cordic_share_arbiter #(
    parameter int NREQ          = 2,
    parameter int DATA_WIDTH    = 16,
    parameter int ANGLE_WIDTH   = 16,
    parameter int CORDIC_STAGES = 16,
    parameter int PEND_WIDTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req,
    output logic [NREQ-1:0]               grant,
    input  logic [NREQ-1:0]               r_vec_en,
    input  logic [NREQ*DATA_WIDTH-1:0]    r_vec_xin,
    input  logic [NREQ*DATA_WIDTH-1:0]    r_vec_yin,
    input  logic [NREQ-1:0]               r_vec_angle_en,
    input  logic [NREQ-1:0]               r_rot_en,
    input  logic [NREQ*DATA_WIDTH-1:0]    r_rot_xin,
    input  logic [NREQ*DATA_WIDTH-1:0]    r_rot_yin,
    input  logic [NREQ*ANGLE_WIDTH-1:0]   r_rot_angle,
    input  logic [NREQ*2-1:0]             r_rot_quad,
    input  logic [NREQ-1:0]               r_rot_mr_n,
    input  logic [NREQ*CORDIC_STAGES-1:0] r_rot_ext,
    input  logic [NREQ-1:0]               r_rot_ext_vld,
    output logic                          cv_en,
    output logic [DATA_WIDTH-1:0]         cv_xin,
    output logic [DATA_WIDTH-1:0]         cv_yin,
    output logic                          cv_angle_en,
    output logic                          cr_en,
    output logic [DATA_WIDTH-1:0]         cr_xin,
    output logic [DATA_WIDTH-1:0]         cr_yin,
    output logic [ANGLE_WIDTH-1:0]        cr_angle,
    output logic [1:0]                    cr_quad,
    output logic                          cr_mr_n,
    output logic [CORDIC_STAGES-1:0]      cr_ext,
    output logic                          cr_ext_vld,
    input  logic                          cv_opvld,
    input  logic [DATA_WIDTH-1:0]         cv_xout,
    input  logic [1:0]                    cv_quad,
    input  logic                          cv_mr_start,
    input  logic                          cr_opvld,
    input  logic [DATA_WIDTH-1:0]         cr_xout,
    output logic [NREQ-1:0]               o_vec_opvld,
    output logic [NREQ-1:0]               o_vec_mr_start,
    output logic [NREQ-1:0]               o_rot_opvld,
    output logic [DATA_WIDTH-1:0]         o_vec_xout,
    output logic [DATA_WIDTH-1:0]         o_rot_xout,
    output logic [1:0]                    o_vec_quad,
    output logic                          busy,
    output logic                          protocol_err
);
    localparam int OW = NREQ > 1 ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;
    state_t                state;
    logic [OW-1:0]         owner, rr, sel;
    logic                  found, live, fwd_v, fwd_r, err_nx;
    logic [NREQ-1:0]       owner_oh;
    logic [PEND_WIDTH-1:0] vec_pend, rot_pend, vec_nx, rot_nx;
    // first requester strictly after the rr pointer, wrapping
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(rr) + k) % NREQ]) begin
                sel   = OW'((int'(rr) + k) % NREQ);
                found = 1'b1;
            end
        end
    end
    assign live           = state != IDLE;
    assign busy           = live;
    assign owner_oh       = NREQ'(1) << owner;
    assign fwd_v          = state == OWN && r_vec_en[owner];
    assign fwd_r          = state == OWN && r_rot_en[owner];
    assign o_vec_opvld    = (cv_opvld && live) ? owner_oh : '0;
    assign o_vec_mr_start = (cv_mr_start && live) ? owner_oh : '0;
    assign o_rot_opvld    = (cr_opvld && live) ? owner_oh : '0;
    assign o_vec_xout     = cv_xout;
    assign o_rot_xout     = cr_xout;
    assign o_vec_quad     = cv_quad;
    // simultaneous issue and return leave a counter unchanged; overflow/underflow flag an error
    always_comb begin
        vec_nx = vec_pend;
        rot_nx = rot_pend;
        err_nx = protocol_err || (!live && cv_mr_start);
        if (fwd_v && !cv_opvld) begin
            if (&vec_pend) err_nx = 1'b1;
            else vec_nx = vec_pend + PEND_WIDTH'(1);
        end else if (!fwd_v && cv_opvld) begin
            if (vec_pend == '0) err_nx = 1'b1;
            else vec_nx = vec_pend - PEND_WIDTH'(1);
        end
        if (fwd_r && !cr_opvld) begin
            if (&rot_pend) err_nx = 1'b1;
            else rot_nx = rot_pend + PEND_WIDTH'(1);
        end else if (!fwd_r && cr_opvld) begin
            if (rot_pend == '0) err_nx = 1'b1;
            else rot_nx = rot_pend - PEND_WIDTH'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= '0;
            rr           <= OW'(NREQ - 1);
            grant        <= '0;
            vec_pend     <= '0;
            rot_pend     <= '0;
            protocol_err <= 1'b0;
            cv_en        <= 1'b0;
            cv_xin       <= '0;
            cv_yin       <= '0;
            cv_angle_en  <= 1'b0;
            cr_en        <= 1'b0;
            cr_xin       <= '0;
            cr_yin       <= '0;
            cr_angle     <= '0;
            cr_quad      <= '0;
            cr_mr_n      <= 1'b0;
            cr_ext       <= '0;
            cr_ext_vld   <= 1'b0;
        end else begin
            vec_pend     <= vec_nx;
            rot_pend     <= rot_nx;
            protocol_err <= err_nx;
            cv_en        <= fwd_v;
            cr_en        <= fwd_r;
            // operand fields only move on an issue, so they hold between pulses
            if (fwd_v) begin
                cv_xin      <= r_vec_xin[owner*DATA_WIDTH +: DATA_WIDTH];
                cv_yin      <= r_vec_yin[owner*DATA_WIDTH +: DATA_WIDTH];
                cv_angle_en <= r_vec_angle_en[owner];
            end
            if (fwd_r) begin
                cr_xin     <= r_rot_xin[owner*DATA_WIDTH +: DATA_WIDTH];
                cr_yin     <= r_rot_yin[owner*DATA_WIDTH +: DATA_WIDTH];
                cr_angle   <= r_rot_angle[owner*ANGLE_WIDTH +: ANGLE_WIDTH];
                cr_quad    <= r_rot_quad[owner*2 +: 2];
                cr_mr_n    <= r_rot_mr_n[owner];
                cr_ext     <= r_rot_ext[owner*CORDIC_STAGES +: CORDIC_STAGES];
                cr_ext_vld <= r_rot_ext_vld[owner];
            end
            case (state)
                IDLE: if (found) begin
                    grant <= NREQ'(1) << sel;
                    owner <= sel;
                    rr    <= sel;
                    state <= OWN;
                end
                OWN: if (!req[owner]) begin
                    grant <= '0;
                    state <= DRAIN;
                end
                DRAIN: if (vec_nx == '0 && rot_nx == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
